// File: rtl/spi_master_sequencer_if.sv
// Host byte-stream bundle for spi_master_sequencer.
// master = host logic, slave = sequencer.
interface spi_master_sequencer_if;
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       i_tx_last;
   logic       o_tx_ready;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;

   modport master (
      output i_tx_data, i_tx_valid, i_tx_last,
      input  o_tx_ready, o_rx_data, o_rx_valid
   );

   modport slave (
      input  i_tx_data, i_tx_valid, i_tx_last,
      output o_tx_ready, o_rx_data, o_rx_valid
   );
endinterface

// File: rtl/spi_master_sequencer.sv
// Mode-0 MSB-first SPI byte master sequencing an external clock_divider.
// SPI_SEQ_LOOPBACK_EN: the rx shifter samples o_mosi instead of i_miso.
module spi_master_sequencer #(
   parameter int unsigned CS_HOLD_CYCLES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [7:0]              i_divisor,
   spi_master_sequencer_if.slave   bus,
   output logic [8:0]              o_div_config,
   output logic                    o_div_start_n,
   input  logic                    i_div_ready,
   input  logic                    i_div_clk,
   input  logic                    i_div_rising_edge,
   input  logic                    i_div_falling_edge,
   output logic                    o_sclk,
   output logic                    o_mosi,
   input  logic                    i_miso,
   output logic                    o_cs_n,
   output logic                    o_busy
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_CS_SETUP    = 3'd1;
   localparam logic [2:0] S_CONFIG      = 3'd2;
   localparam logic [2:0] S_CONFIG_WAIT = 3'd3;
   localparam logic [2:0] S_START       = 3'd4;
   localparam logic [2:0] S_SHIFT       = 3'd5;
   localparam logic [2:0] S_BYTE_DONE   = 3'd6;
   localparam logic [2:0] S_CS_HOLD     = 3'd7;

   localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD_CYCLES - 1);

   logic [2:0] r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_tx;
   logic [7:0] r_rx;
   logic [7:0] r_div;
   logic [7:0] r_cfg_div;
   logic [7:0] r_rx_data;
   logic       r_last;
   logic       r_cfg_vld;
   logic       r_seen_low;
   logic       r_cs_n;
   logic       r_mosi;
   logic       r_rx_valid;

   logic [7:0] w_div_even;
   logic [7:0] w_div_norm;
   logic       w_accept;
   logic       w_cfg_stb;
   logic       w_start_stb;
   logic       w_hold_done;
   logic       w_need_cfg;
   logic       w_rx_bit;

`ifdef SPI_SEQ_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = i_miso;
   assign w_rx_bit      = r_mosi;
`else
   assign w_rx_bit      = i_miso;
`endif

   assign w_div_even  = {i_divisor[7:1], 1'b0};
   assign w_div_norm  = (w_div_even == 8'd0) ? 8'd2 : w_div_even;
   assign w_cfg_stb   = (r_state == S_CONFIG) & i_div_ready;
   assign w_start_stb = (r_state == S_START) & i_div_ready;
   assign w_hold_done = (r_cnt == HOLD_LAST);
   assign w_need_cfg  = !r_cfg_vld | (r_div != r_cfg_div);
   assign w_accept    = bus.i_tx_valid & bus.o_tx_ready;

   assign bus.o_tx_ready = (r_state == S_IDLE) |
                           ((r_state == S_BYTE_DONE) & !r_last);
   assign bus.o_rx_data  = r_rx_data;
   assign bus.o_rx_valid = r_rx_valid;

   // Divisor bits are only meaningful during the strobe cycle.
   assign o_div_config  = {w_cfg_stb ? r_div : 8'h00, w_cfg_stb};
   assign o_div_start_n = !w_start_stb;
   assign o_sclk        = i_div_clk;
   assign o_mosi        = r_mosi;
   assign o_cs_n        = r_cs_n;
   assign o_busy        = (r_state != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_tx       <= 8'd0;
         r_rx       <= 8'd0;
         r_div      <= 8'd0;
         r_cfg_div  <= 8'd0;
         r_rx_data  <= 8'd0;
         r_last     <= 1'b0;
         r_cfg_vld  <= 1'b0;
         r_seen_low <= 1'b0;
         r_cs_n     <= 1'b1;
         r_mosi     <= 1'b0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx    <= bus.i_tx_data;
                  r_last  <= bus.i_tx_last;
                  r_div   <= w_div_norm;
                  r_mosi  <= bus.i_tx_data[7];
                  r_cs_n  <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_state <= S_CS_SETUP;
               end
            end
            S_CS_SETUP: begin
               if (w_hold_done)
                  r_state <= w_need_cfg ? S_CONFIG : S_START;
               else
                  r_cnt <= r_cnt + 8'd1;
            end
            S_CONFIG: begin
               if (i_div_ready) begin
                  r_cfg_div  <= r_div;
                  r_cfg_vld  <= 1'b1;
                  r_seen_low <= 1'b0;
                  r_state    <= S_CONFIG_WAIT;
               end
            end
            S_CONFIG_WAIT: begin
               if (!i_div_ready)
                  r_seen_low <= 1'b1;
               else if (r_seen_low)
                  r_state <= S_START;
            end
            S_START: begin
               if (i_div_ready) begin
                  r_seen_low <= 1'b0;
                  r_rx       <= 8'd0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (i_div_rising_edge)
                  r_rx <= {r_rx[6:0], w_rx_bit};
               if (i_div_falling_edge) begin
                  r_tx   <= {r_tx[6:0], 1'b0};
                  r_mosi <= r_tx[6];
               end
               // Ready must drop before its return marks the byte end.
               if (!i_div_ready) begin
                  r_seen_low <= 1'b1;
               end else if (r_seen_low) begin
                  r_rx_data  <= r_rx;
                  r_rx_valid <= 1'b1;
                  r_state    <= S_BYTE_DONE;
               end
            end
            S_BYTE_DONE: begin
               if (r_last) begin
                  r_cnt   <= 8'd0;
                  r_state <= S_CS_HOLD;
               end else if (bus.i_tx_valid) begin
                  r_tx    <= bus.i_tx_data;
                  r_last  <= bus.i_tx_last;
                  r_mosi  <= bus.i_tx_data[7];
                  r_state <= S_START;
               end
            end
            S_CS_HOLD: begin
               if (w_hold_done) begin
                  r_cs_n  <= 1'b1;
                  r_mosi  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
